mul_sequencer: RTL

- Multicycle shift-add multiplier controller and datapath.
- Serves the CPU's multiply opcode (15): the control unit pulses `start` with both register operands.
- Block runs one add/shift step per cycle and holds the 2·WIDTH product for the HI/LO move opcodes (13/14).
- `busy` is the stall source that freezes PC/write-back while a multiply is in flight.

---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_step.sv | 23 ++
 rtl/mul_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-add multiplier.
// abs_val is only referenced when MUL_SIGNED_EN is defined.
package mul_pkg;

  localparam int unsigned DefaultWidth = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Magnitude of a sign-extended two's complement value; the most negative
  // operand maps to its positive magnitude in the low bits.
  function automatic logic [63:0] abs_val(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One combinational add/shift step of the shift-add multiplier.
module mul_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mq_o
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  always_comb begin
    addend = mq_i[0] ? {1'b0, mcand_i} : '0;
    sum    = {1'b0, acc_i} + addend;
    // {sum, mq} >> 1, keeping the low 2*WIDTH bits
    acc_o  = sum[WIDTH:1];
    mq_o   = {sum[0], mq_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multicycle shift-add multiplier: FSM, operand/product registers and HI/LO result.
// Define MUL_SIGNED_EN for two's complement operands.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mq_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   mcand_in;
  logic [WIDTH-1:0]   mq_in;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   mq_next;
  logic [2*WIDTH-1:0] result;

  assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MUL_SIGNED_EN
  logic        neg_q;
  logic        neg_in;
  logic [63:0] abs_a;
  logic [63:0] abs_b;

  assign abs_a    = abs_val(64'($signed(op_a)));
  assign abs_b    = abs_val(64'($signed(op_b)));
  assign mcand_in = abs_a[WIDTH-1:0];
  assign mq_in    = abs_b[WIDTH-1:0];
  assign neg_in   = op_a[WIDTH-1] ^ op_b[WIDTH-1];
  assign result   = neg_q ? -{acc_next, mq_next} : {acc_next, mq_next};

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_in;
    end
  end
`else
  assign mcand_in = op_a;
  assign mq_in    = op_b;
  assign result   = {acc_next, mq_next};
`endif

  mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i   (acc_q),
    .mq_i    (mq_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_next),
    .mq_o    (mq_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= StRun;
        cnt_q   <= '0;
        mcand_q <= mcand_in;
        acc_q   <= '0;
        mq_q    <= mq_in;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          StRun: begin
            acc_q <= acc_next;
            mq_q  <= mq_next;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
              // Result registers load on the same edge that enters DONE
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hi_q    <= result[2*WIDTH-1:WIDTH];
              lo_q    <= result[WIDTH-1:0];
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
